// File: rtl/wb_commit_unit.sv
// Writeback commit stage: selects the result source, waits for load data when needed,
// and drives a registered register-file write port plus a retired-result counter.
module wb_commit_unit #(
  parameter int unsigned DATA = 32,
  parameter int unsigned ADDR = 5
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [ADDR-1:0] in_rd,
  input  logic [1:0]      in_src,
  input  logic [2:0]      in_funct3,
  input  logic [DATA-1:0] in_alu,
  input  logic [DATA-1:0] in_pc4,
  input  logic [DATA-1:0] in_imm,
  input  logic [DATA-1:0] mem_rdata,
  input  logic            mem_ready,
  output logic            WE,
  output logic [ADDR-1:0] WA,
  output logic [DATA-1:0] WD,
  output logic [DATA-1:0] retire_cnt
);

  typedef enum logic [0:0] {StIdle, StWaitMem} state_e;

  state_e          state_q, state_d;
  logic            we_q;
  logic [ADDR-1:0] wa_q, wa_d;
  logic [DATA-1:0] wd_q, wd_d;
  logic [DATA-1:0] cnt_q;
  logic [ADDR-1:0] ld_rd_q, ld_rd_d;
  logic [2:0]      ld_f3_q, ld_f3_d;
  logic [1:0]      ld_off_q, ld_off_d;

  logic            accept;
  logic            commit;
  logic [DATA-1:0] src_sel;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [DATA-1:0] ld_ext;

  assign in_ready = (state_q == StIdle);
  assign accept   = in_valid && in_ready;

  always_comb begin
    src_sel = in_alu;
    unique case (in_src)
      2'b00:   src_sel = in_alu;
      2'b10:   src_sel = in_pc4;
      2'b11:   src_sel = in_imm;
      default: src_sel = in_alu;
    endcase
  end

  // Byte/halfword lanes assume a 32-bit-or-wider data word.
  assign ld_byte = mem_rdata[{ld_off_q, 3'b000} +: 8];
  assign ld_half = ld_off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    ld_ext = mem_rdata;
    case (ld_f3_q)
      3'b000:  ld_ext = {{(DATA-8){ld_byte[7]}}, ld_byte};
      3'b001:  ld_ext = {{(DATA-16){ld_half[15]}}, ld_half};
      3'b010:  ld_ext = mem_rdata;
      3'b100:  ld_ext = {{(DATA-8){1'b0}}, ld_byte};
      3'b101:  ld_ext = {{(DATA-16){1'b0}}, ld_half};
      default: ld_ext = mem_rdata;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    commit   = 1'b0;
    wa_d     = wa_q;
    wd_d     = wd_q;
    ld_rd_d  = ld_rd_q;
    ld_f3_d  = ld_f3_q;
    ld_off_d = ld_off_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (in_src == 2'b01) begin
            ld_rd_d  = in_rd;
            ld_f3_d  = in_funct3;
            ld_off_d = in_alu[1:0];
            state_d  = StWaitMem;
          end else begin
            commit = 1'b1;
            wa_d   = in_rd;
            wd_d   = src_sel;
          end
        end
      end
      StWaitMem: begin
        if (mem_ready) begin
          commit  = 1'b1;
          wa_d    = ld_rd_q;
          wd_d    = ld_ext;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= StIdle;
      we_q     <= 1'b0;
      wa_q     <= '0;
      wd_q     <= '0;
      cnt_q    <= '0;
      ld_rd_q  <= '0;
      ld_f3_q  <= '0;
      ld_off_q <= '0;
    end else begin
      state_q  <= state_d;
      // x0 writes are suppressed but still retire.
      we_q     <= commit && (wa_d != '0);
      wa_q     <= wa_d;
      wd_q     <= wd_d;
      cnt_q    <= cnt_q + {{(DATA-1){1'b0}}, commit};
      ld_rd_q  <= ld_rd_d;
      ld_f3_q  <= ld_f3_d;
      ld_off_q <= ld_off_d;
    end
  end

  assign WE         = we_q;
  assign WA         = wa_q;
  assign WD         = wd_q;
  assign retire_cnt = cnt_q;

endmodule

// File: tb/tb_wb_commit_unit.sv
// Scoreboard bench for wb_commit_unit: stimulus pushes expected commits, a monitor
// pops and compares whenever a commit shows up (WE pulse or retire count change).
module tb_wb_commit_unit;

  logic        clk;
  logic        rstn;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic [1:0]  in_src;
  logic [2:0]  in_funct3;
  logic [31:0] in_alu, in_pc4, in_imm;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        WE;
  logic [4:0]  WA;
  logic [31:0] WD;
  logic [31:0] retire_cnt;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [31:0] cnt;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_cnt = 0;

  wb_commit_unit #(.DATA(32), .ADDR(5)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_rd      (in_rd),
    .in_src     (in_src),
    .in_funct3  (in_funct3),
    .in_alu     (in_alu),
    .in_pc4     (in_pc4),
    .in_imm     (in_imm),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .WE         (WE),
    .WA         (WA),
    .WD         (WD),
    .retire_cnt (retire_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic push(input logic [4:0] rd, input logic [31:0] wd);
    exp_t e;
    exp_cnt = exp_cnt + 32'd1;
    e.we  = (rd != 5'd0);
    e.wa  = rd;
    e.wd  = wd;
    e.cnt = exp_cnt;
    sb.push_back(e);
  endtask

  // Drive a non-load result for the upcoming edge; caller owns the timing.
  task automatic drive_result(input logic [1:0] src, input logic [4:0] rd,
                              input logic [31:0] val);
    in_valid = 1'b1;
    in_src   = src;
    in_rd    = rd;
    in_alu   = 32'hA1A1_0000;
    in_pc4   = 32'hB2B2_0000;
    in_imm   = 32'hC3C3_0000;
    case (src)
      2'b00:   in_alu = val;
      2'b10:   in_pc4 = val;
      default: in_imm = val;
    endcase
    push(rd, val);
  endtask

  // Load with mem_ready raised for the edge 'lat' cycles after the accept edge.
  task automatic do_load(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] off,
                         input logic [31:0] rdata, input int lat, input logic [31:0] exp_wd);
    @(negedge clk);
    in_valid  = 1'b1;
    in_src    = 2'b01;
    in_rd     = rd;
    in_funct3 = f3;
    in_alu    = {30'h0, off};
    mem_rdata = rdata;
    mem_ready = 1'b1;  // must be ignored while idle
    @(negedge clk);
    in_valid = 1'b0;
    in_rd    = 5'd31;
    for (int i = 1; i <= lat; i++) begin
      check("ready_low_wait", {31'h0, in_ready}, 32'h0);
      mem_ready = (i == lat);
      if (i == lat) push(rd, exp_wd);
      @(negedge clk);
    end
    mem_ready = 1'b0;
  endtask

  // Monitor: one sample per cycle, 1 time unit after the rising edge.
  initial begin
    exp_t        e;
    logic [31:0] mon_cnt;
    logic [4:0]  last_wa;
    logic [31:0] last_wd;
    mon_cnt = 0;
    last_wa = 0;
    last_wd = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!rstn) begin
        mon_cnt = 0;
        last_wa = 0;
        last_wd = 0;
      end else if (WE || retire_cnt !== mon_cnt) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL spurious_commit: WE=%0b WA=%0d WD=0x%08h cnt=%0d, want no commit",
                   WE, WA, WD, retire_cnt);
          mon_cnt = retire_cnt;
        end else begin
          e = sb.pop_front();
          if (WE !== e.we || WA !== e.wa || WD !== e.wd || retire_cnt !== e.cnt) begin
            bad++;
            $display("FAIL commit: got WE=%0b WA=%0d WD=0x%08h cnt=0x%08h, want WE=%0b WA=%0d WD=0x%08h cnt=0x%08h",
                     WE, WA, WD, retire_cnt, e.we, e.wa, e.wd, e.cnt);
          end
          mon_cnt = e.cnt;
          last_wa = e.wa;
          last_wd = e.wd;
        end
      end else begin
        total++;
        if (WA !== last_wa || WD !== last_wd) begin
          bad++;
          $display("FAIL idle_hold: got WA=%0d WD=0x%08h, want WA=%0d WD=0x%08h",
                   WA, WD, last_wa, last_wd);
        end
      end
    end
  end

  initial begin
    rstn      = 1'b0;
    in_valid  = 1'b0;
    in_rd     = 5'd0;
    in_src    = 2'b00;
    in_funct3 = 3'b000;
    in_alu    = 32'h0;
    in_pc4    = 32'h0;
    in_imm    = 32'h0;
    mem_rdata = 32'h0;
    mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ready", {31'h0, in_ready}, 32'h1);
    check("rst_we", {31'h0, WE}, 32'h0);
    check("rst_wa", {27'h0, WA}, 32'h0);
    check("rst_wd", WD, 32'h0);
    check("rst_cnt", retire_cnt, 32'h0);
    rstn = 1'b1;
    check("ready_after_rst", {31'h0, in_ready}, 32'h1);

    // ALU, then PC+4 to x0, then IMM
    @(negedge clk); drive_result(2'b00, 5'd5, 32'h0000_1234);
    @(negedge clk); drive_result(2'b10, 5'd0, 32'h0000_0104);
    @(negedge clk); drive_result(2'b11, 5'd3, 32'hDEAD_BEEF);
    @(negedge clk); in_valid = 1'b0;

    do_load(5'd7,  3'b000, 2'd2, 32'h0080_0000, 3, 32'hFFFF_FF80);  // LB
    do_load(5'd9,  3'b101, 2'd2, 32'hBEEF_0000, 1, 32'h0000_BEEF);  // LHU
    do_load(5'd10, 3'b010, 2'd2, 32'hBEEF_0000, 2, 32'hBEEF_0000);  // LW
    do_load(5'd11, 3'b001, 2'd3, 32'h8001_1234, 1, 32'hFFFF_8001);  // LH, offset[0] ignored
    do_load(5'd12, 3'b100, 2'd1, 32'h0000_AB00, 1, 32'h0000_00AB);  // LBU
    do_load(5'd13, 3'b011, 2'd1, 32'h1357_9BDF, 1, 32'h1357_9BDF);  // raw
    do_load(5'd0,  3'b010, 2'd0, 32'h7777_7777, 2, 32'h7777_7777);  // load to x0

    // Reset while a load is pending; a later mem_ready must be dropped.
    @(negedge clk);
    in_valid  = 1'b1;
    in_src    = 2'b01;
    in_rd     = 5'd4;
    in_funct3 = 3'b010;
    @(negedge clk);
    in_valid = 1'b0;
    check("pend_ready_low", {31'h0, in_ready}, 32'h0);
    #2 rstn = 1'b0;
    #1;
    check("async_rst_ready", {31'h0, in_ready}, 32'h1);
    check("async_rst_cnt", retire_cnt, 32'h0);
    check("async_rst_wa", {27'h0, WA}, 32'h0);
    exp_cnt = 0;
    @(negedge clk);
    rstn      = 1'b1;
    mem_ready = 1'b1;
    mem_rdata = 32'h5555_AAAA;
    check("ready_first_cycle", {31'h0, in_ready}, 32'h1);
    @(negedge clk);
    mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("post_rst_we", {31'h0, WE}, 32'h0);
    check("post_rst_cnt", retire_cnt, 32'h0);
    check("post_rst_ready", {31'h0, in_ready}, 32'h1);

    // Four back-to-back ALU commits
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive_result(2'b00, 5'(i + 1), 32'h100 + 32'(i));
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("b2b_cnt", retire_cnt, 32'd4);

    // Counter wrap
    @(negedge clk);
    force dut.cnt_q = 32'hFFFF_FFFF;
    #1 release dut.cnt_q;
    exp_cnt = 32'hFFFF_FFFF;
    drive_result(2'b00, 5'd2, 32'h0000_0042);
    @(negedge clk);
    in_valid = 1'b0;
    check("wrap_cnt", retire_cnt, 32'h0);

    repeat (4) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
